vga_rx_capture: RTL and testbench

- VGA sink: decodes hsync/vsync/rgb from the display controller back into pixel coordinates and data, one pixel per clock.
- Sits on the far end of the VGA output, on-chip in loopback or as a bench/monitor block.
- Locks to sync edges and checks line and frame geometry against 640x480@60 timing.
- Emits a pixel stream plus lock and error status.

---
 rtl/vga_rx_capture.sv | 146 ++++++++++++++
 tb/tb_vga_rx_capture.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_capture.sv
// VGA sink: locks to hsync/vsync edges, verifies line/frame geometry and
// turns the rgb stream back into (x, y, colour) pixels with lock/error status.
module vga_rx_capture #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk25MHz,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] rgb,
    output logic       pixel_valid,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic [7:0] pixel_rgb,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_error
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic       hsync_q, vsync_q, hsync_q1, vsync_q1;
    logic [7:0] rgb_q;
    logic [9:0] hcount, vcount;

    logic       h_edge_p1, v_edge_p1, err_p1, vld_p1;
    logic [9:0] h_pos_p1, v_pos_p1;

    function automatic logic [9:0] sat_inc(input logic [9:0] val, input logic [9:0] lim);
        return (val >= lim) ? lim : val + 10'd1;
    endfunction

    // Stage 1: pin capture plus previous-cycle sync copies for edge detection
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            hsync_q1 <= 1'b1;
            vsync_q1 <= 1'b1;
            rgb_q    <= '0;
        end else begin
            hsync_q  <= hsync;
            vsync_q  <= vsync;
            hsync_q1 <= hsync_q;
            vsync_q1 <= vsync_q;
            rgb_q    <= rgb;
        end
    end

    // h_pos/v_pos are the coordinates of the sample now in stage 1;
    // hcount/vcount hold those of the previous sample.
    always_comb begin
        h_edge_p1 = hsync_q1 & ~hsync_q;
        v_edge_p1 = vsync_q1 & ~vsync_q;
        h_pos_p1  = h_edge_p1 ? '0 : sat_inc(hcount, H_TOT);
        if (v_edge_p1)
            v_pos_p1 = '0;
        else if (h_edge_p1)
            v_pos_p1 = sat_inc(vcount, V_TOT);
        else
            v_pos_p1 = vcount;

        err_p1 = (state != SEARCH) &&
                 ((h_edge_p1 && (hcount != H_LAST)) ||
                  (v_edge_p1 && (vcount != V_LAST)) ||
                  (h_pos_p1 == H_TOT) || (v_pos_p1 == V_TOT));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (v_edge_p1) state_nxt = MEASURE;
            MEASURE: begin
                if (err_p1)
                    state_nxt = SEARCH;
                else if (v_edge_p1)
                    state_nxt = LOCKED;
            end
            LOCKED:  if (err_p1) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase

        vld_p1 = (state_nxt == LOCKED) &&
                 (h_pos_p1 >= H_START) && (h_pos_p1 <= H_END) &&
                 (v_pos_p1 >= V_START) && (v_pos_p1 <= V_END);
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            state  <= SEARCH;
            hcount <= '0;
            vcount <= '0;
        end else begin
            state  <= state_nxt;
            hcount <= h_pos_p1;
            vcount <= v_pos_p1;
        end
    end

    // Stage 2: registered pixel stream and status
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_rgb   <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            pixel_valid <= vld_p1;
            pixel_x     <= vld_p1 ? h_pos_p1 - H_START : '0;
            pixel_y     <= vld_p1 ? v_pos_p1 - V_START : '0;
            pixel_rgb   <= vld_p1 ? rgb_q : '0;
            frame_start <= vld_p1 && (h_pos_p1 == H_START) && (v_pos_p1 == V_START);
            locked      <= (state_nxt == LOCKED);
            sync_error  <= err_p1;
        end
    end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture on a scaled-down 16x8 raster (25x14 total),
// with a sample-level reference model compared on every clock.
module tb_vga_rx_capture;

    localparam int HA = 16, HFP = 2, HSY = 4, HBP = 3;
    localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 3;
    localparam int HT = HA + HFP + HSY + HBP;   // 25
    localparam int VT = VA + VFP + VSY + VBP;   // 14
    localparam int HS = HSY + HBP;              // 7
    localparam int VS = VSY + VBP;              // 5

    logic       clk25MHz, reset, hsync, vsync;
    logic [7:0] rgb;
    logic       pixel_valid, frame_start, locked, sync_error;
    logic [9:0] pixel_x, pixel_y;
    logic [7:0] pixel_rgb;

    vga_rx_capture #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk25MHz(clk25MHz), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_rgb(pixel_rgb), .frame_start(frame_start), .locked(locked),
        .sync_error(sync_error)
    );

    initial begin
        clk25MHz = 1'b0;
        forever #20 clk25MHz = ~clk25MHz;
    end

    typedef struct packed {
        logic       vld;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] c;
        logic       fs;
        logic       lk;
        logic       se;
    } out_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state: previous pin syncs, sample position, lock progress
    logic m_ph, m_pv;
    int   m_col, m_row, m_mode;
    out_t exp_now, exp_pipe;

    // observation windows
    int   n_vld, n_fs, n_err, n_rgb_bad;
    int   lock_cyc = -1;
    logic lk_prev = 1'b0;
    int   fs_cyc, ab_cyc;
    logic [9:0] fs_x, fs_y;
    logic [7:0] fs_rgb;
    int   rgb_mode = 0;

    function automatic out_t dut_outs();
        out_t o;
        o.vld = pixel_valid; o.x = pixel_x; o.y = pixel_y; o.c = pixel_rgb;
        o.fs = frame_start;  o.lk = locked; o.se = sync_error;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, req, req);
        end
    endtask

    task automatic model_reset();
        m_ph = 1'b1; m_pv = 1'b1; m_col = 0; m_row = 0; m_mode = 0;
        exp_now = '0; exp_pipe = '0;
    endtask

    // One pin sample: a line must last exactly HT samples, a frame exactly VT lines.
    task automatic model_step(input logic h, input logic v, input logic [7:0] c);
        logic hf, vf, err, act;
        int   line_len, frame_len;
        out_t e;
        hf = m_ph && !h;
        vf = m_pv && !v;
        line_len  = m_col + 1;
        frame_len = m_row + 1;
        m_col = hf ? 0 : m_col + 1;
        if (vf)      m_row = 0;
        else if (hf) m_row = m_row + 1;
        err = (m_mode != 0) && ((hf && line_len != HT) || (vf && frame_len != VT) ||
                                (m_col >= HT) || (m_row >= VT));
        if (err)     m_mode = 0;
        else if (vf) m_mode = (m_mode == 0) ? 1 : 2;
        act = (m_mode == 2) && (m_col >= HS) && (m_col < HS + HA) &&
              (m_row >= VS) && (m_row < VS + VA);
        e.vld = act;
        e.x   = act ? 10'(m_col - HS) : 10'd0;
        e.y   = act ? 10'(m_row - VS) : 10'd0;
        e.c   = act ? c : 8'd0;
        e.fs  = act && (m_col == HS) && (m_row == VS);
        e.lk  = (m_mode == 2);
        e.se  = err;
        exp_pipe = e;
        m_ph = h;
        m_pv = v;
    endtask

    task automatic tick(input logic h, input logic v, input logic [7:0] c, input logic r);
        out_t got;
        hsync = h; vsync = v; rgb = c; reset = r;
        @(posedge clk25MHz);
        cyc++;
        if (r) model_reset();
        else begin
            exp_now = exp_pipe;
            model_step(h, v, c);
        end
        @(negedge clk25MHz);
        got = dut_outs();
        checks++;
        if (got !== exp_now) begin
            errors++;
            $display("FAIL cycle_model cyc=%0d got vld=%b x=%0d y=%0d rgb=%h fs=%b lk=%b se=%b expected vld=%b x=%0d y=%0d rgb=%h fs=%b lk=%b se=%b",
                     cyc, got.vld, got.x, got.y, got.c, got.fs, got.lk, got.se,
                     exp_now.vld, exp_now.x, exp_now.y, exp_now.c, exp_now.fs, exp_now.lk, exp_now.se);
        end
        if (pixel_valid) n_vld++;
        if (sync_error) n_err++;
        if (pixel_valid && pixel_rgb !== pixel_x[7:0]) n_rgb_bad++;
        if (frame_start) begin
            n_fs++; fs_cyc = cyc; fs_x = pixel_x; fs_y = pixel_y; fs_rgb = pixel_rgb;
        end
        if (locked && !lk_prev && lock_cyc < 0) lock_cyc = cyc;
        lk_prev = locked;
    endtask

    task automatic clear_win();
        n_vld = 0; n_fs = 0; n_err = 0; n_rgb_bad = 0; fs_cyc = -1;
    endtask

    task automatic gen_frame(input int lines, input int short_line, input int rst_line, input int rst_col);
        int len;
        logic [7:0] c;
        logic act, r;
        for (int ln = 0; ln < lines; ln++) begin
            len = (ln == short_line) ? HT - 1 : HT;
            for (int col = 0; col < len; col++) begin
                act = (col >= HS) && (col < HS + HA) && (ln >= VS) && (ln < VS + VA);
                if (rgb_mode == 0)
                    c = act ? 8'(col - HS) : 8'hFF;
                else
                    c = (col == HS && ln == VS) ? 8'hAB : 8'h00;
                r = (ln == rst_line) && (col == rst_col);
                tick(col >= HSY, ln >= VSY, c, r);
                if (c == 8'hAB && rgb_mode == 1) ab_cyc = cyc;
                if (r) chk("reset_mid_outputs", dut_outs(), 32'd0);
            end
        end
    endtask

    int f2;

    initial begin
        reset = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = 8'h00;
        model_reset();
        clear_win();
        repeat (3) tick(1'b1, 1'b1, 8'h00, 1'b1);
        chk("reset_outputs", dut_outs(), 32'd0);
        repeat (5) tick(1'b1, 1'b1, 8'h55, 1'b0);

        // three nominal frames; lock at the second vsync fall
        gen_frame(VT, -1, -1, -1);
        f2 = cyc + 1;
        gen_frame(VT, -1, -1, -1);
        chk("lock_rise_cycle", lock_cyc, f2 + 1);
        clear_win();
        gen_frame(VT, -1, -1, -1);
        chk("f3_pixel_count", n_vld, 128);
        chk("f3_frame_starts", n_fs, 1);
        chk("f3_rgb_eq_x", n_rgb_bad, 0);
        chk("f3_locked", locked, 1);

        // short line (24 clocks) on row 7 = active line y=2
        clear_win();
        gen_frame(VT, 7, -1, -1);
        chk("short_err_pulses", n_err, 1);
        chk("short_pixels", n_vld, 48);
        chk("short_locked", locked, 0);
        clear_win();
        gen_frame(VT, -1, -1, -1);
        chk("n1_pixels", n_vld, 0);
        chk("n1_locked", locked, 0);
        clear_win();
        gen_frame(VT, -1, -1, -1);
        chk("n2_pixels", n_vld, 128);
        chk("n2_locked", locked, 1);

        // hsync stuck high while locked
        clear_win();
        repeat (40) tick(1'b1, 1'b1, 8'h33, 1'b0);
        chk("hold_err_pulses", n_err, 1);
        chk("hold_locked", locked, 0);
        chk("hold_hcount_sat", 32'(dut.hcount), 25);

        // relock, then a frame one line short
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT - 1, -1, -1, -1);
        chk("pre_short_frame_locked", locked, 1);
        clear_win();
        gen_frame(VT, -1, -1, -1);
        chk("short_frame_err", n_err, 1);
        chk("short_frame_locked", locked, 0);

        // relock, then reset at pixel (8,4): column 15, line 9
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, 9, HS + 8);
        gen_frame(VT, -1, -1, -1);
        chk("after_reset_g_locked", locked, 0);

        // single marked pixel at (0,0)
        rgb_mode = 1;
        clear_win();
        gen_frame(VT, -1, -1, -1);
        chk("ab_locked", locked, 1);
        chk("ab_frame_starts", n_fs, 1);
        chk("ab_rgb", fs_rgb, 8'hAB);
        chk("ab_x", fs_x, 0);
        chk("ab_y", fs_y, 0);
        chk("ab_latency", fs_cyc, ab_cyc + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
